// File: rtl/fill_arbiter.sv
// fill_arbiter: shares one backing-memory port between I-cache line fills,
// D-cache line fills and D-side write-through stores.
//
// Ports
//   clk, rst                  clock and asynchronous active-high reset
//   i_miss, i_addr            I-cache miss request and byte address (held until filled)
//   d_miss, d_wr, d_addr,     D-cache read miss / write-through store request,
//   d_wdata                   shared byte address and store data
//   mem_addr, mem_enable,     backing-memory request (one per cycle)
//   mem_wr, mem_wdata
//   mem_data_valid, mem_rdata backing-memory read return, MEM_LAT cycles after enable
//   fill_data, fill_word      word written into the selected cache data array
//   fill_we_i, fill_we_d      per-word write enables
//   fill_done_i, fill_done_d  last-word pulse (tag/valid write)
//   IF_stall, MEM_stall       pipeline stalls
//
// state  | meaning
// IDLE   | no transaction; arbitrate d_wr > d_miss > i_miss
// WRITE  | single-cycle write-through store
// FILL_I | 8-word line fill for the I-cache
// FILL_D | 8-word line fill for the D-cache
module fill_arbiter #(
    parameter int MEM_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss,
    input  logic [15:0] i_addr,
    input  logic        d_miss,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] mem_addr,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_rdata,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_word,
    output logic        fill_we_i,
    output logic        fill_we_d,
    output logic        fill_done_i,
    output logic        fill_done_d,
    output logic        IF_stall,
    output logic        MEM_stall
);

    if (MEM_LAT < 1) begin : g_lat_check
        $error("fill_arbiter: MEM_LAT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} state_t;

    state_t      state;
    state_t      next_state;
    logic [2:0]  issue_cnt;
    logic [2:0]  recv_cnt;
    logic        issue_done;
    logic [15:0] base;

    logic in_fill;
    logic issuing;
    logic fill_we;
    logic last_word;

    assign in_fill   = (state == FILL_I) || (state == FILL_D);
    assign issuing   = in_fill && !issue_done;
    assign fill_we   = in_fill && mem_data_valid && !rst;
    assign last_word = fill_we && (recv_cnt == 3'd7);

    // The last-word cycle hands the port straight to another pending
    // requester, skipping IDLE. The owner of the finishing fill is excluded
    // because it still holds its miss during the done cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (d_wr)        next_state = WRITE;
                else if (d_miss) next_state = FILL_D;
                else if (i_miss) next_state = FILL_I;
            end
            WRITE: next_state = IDLE;
            FILL_I: begin
                if (last_word) begin
                    if (d_wr)        next_state = WRITE;
                    else if (d_miss) next_state = FILL_D;
                    else             next_state = IDLE;
                end
            end
            FILL_D: begin
                if (last_word) begin
                    if (d_wr)        next_state = WRITE;
                    else if (i_miss) next_state = FILL_I;
                    else             next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            issue_cnt  <= 3'd0;
            recv_cnt   <= 3'd0;
            issue_done <= 1'b0;
            base       <= 16'h0000;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                issue_cnt  <= 3'd0;
                recv_cnt   <= 3'd0;
                issue_done <= 1'b0;
                if (next_state == FILL_I) base <= i_addr & 16'hFFF0;
                if (next_state == FILL_D) base <= d_addr & 16'hFFF0;
            end else begin
                if (issuing) begin
                    issue_cnt <= issue_cnt + 3'd1;
                    if (issue_cnt == 3'd7) issue_done <= 1'b1;
                end
                if (fill_we) recv_cnt <= recv_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        mem_enable = (state == WRITE) || issuing;
        mem_wr     = (state == WRITE);
        mem_wdata  = (state == WRITE) ? d_wdata : 16'h0000;
        if (state == WRITE)
            mem_addr = d_addr;
        else if (issuing)
            mem_addr = base + {12'd0, issue_cnt, 1'b0};
        else
            mem_addr = 16'h0000;
    end

    assign fill_we_i   = fill_we && (state == FILL_I);
    assign fill_we_d   = fill_we && (state == FILL_D);
    assign fill_data   = fill_we ? mem_rdata : 16'h0000;
    assign fill_word   = fill_we ? recv_cnt : 3'd0;
    assign fill_done_i = last_word && (state == FILL_I);
    assign fill_done_d = last_word && (state == FILL_D);

    assign IF_stall  = (i_miss || (state == FILL_I)) && !fill_done_i;
    assign MEM_stall = (d_miss || d_wr || (state == FILL_D)) && !fill_done_d
                       && (state != WRITE);

endmodule

// File: tb/tb_fill_arbiter.sv
module tb_fill_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss;
    logic [15:0] i_addr;
    logic        d_miss;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic        mem_data_valid;
    logic [15:0] mem_rdata;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        fill_we_i;
    logic        fill_we_d;
    logic        fill_done_i;
    logic        fill_done_d;
    logic        IF_stall;
    logic        MEM_stall;

    logic        inject;
    bit          pipe_v [0:LAT-1];
    bit   [15:0] pipe_a [0:LAT-1];

    typedef struct packed {
        logic        side_d;
        logic [2:0]  word;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    fill_arbiter #(.MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_addr(i_addr),
        .d_miss(d_miss), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata),
        .fill_data(fill_data), .fill_word(fill_word),
        .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
        .fill_done_i(fill_done_i), .fill_done_d(fill_done_d),
        .IF_stall(IF_stall), .MEM_stall(MEM_stall)
    );

    always #5 clk = ~clk;

    // Backing memory: fixed-latency read pipe, unaffected by rst so that
    // returns issued before a reset still arrive afterwards.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    always @(posedge clk) begin
        pipe_v[0] <= mem_enable && !mem_wr;
        pipe_a[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
        end
    end

    assign mem_data_valid = pipe_v[LAT-1] || inject;
    assign mem_rdata      = inject ? 16'hDEAD : (pipe_v[LAT-1] ? mem_word(pipe_a[LAT-1]) : 16'h0000);

    // Scoreboard: each fill word written to a cache is popped and compared.
    always @(negedge clk) begin
        exp_t e;
        logic [1:0] exp_done;
        if (fill_we_i || fill_we_d) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_write: we_i=%b we_d=%b word=%0d data=%h, required no write", fill_we_i, fill_we_d, fill_word, fill_data);
            end else begin
                e = sb.pop_front();
                exp_done = (e.word == 3'd7) ? (e.side_d ? 2'b10 : 2'b01) : 2'b00;
                if ({fill_we_d, fill_we_i, fill_word, fill_data} !== {e.side_d, ~e.side_d, e.word, e.data}) begin
                    miscompares++;
                    $display("FAIL sb_word: got we_d=%b we_i=%b word=%0d data=%h, required we_d=%b word=%0d data=%h", fill_we_d, fill_we_i, fill_word, fill_data, e.side_d, e.word, e.data);
                end
                if ({fill_done_d, fill_done_i} !== exp_done) begin
                    miscompares++;
                    $display("FAIL sb_done: got done_d/i=%b%b, required %b", fill_done_d, fill_done_i, exp_done);
                end
            end
        end else if (fill_done_i || fill_done_d) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_spurious_done: done_d=%b done_i=%b without a fill write", fill_done_d, fill_done_i);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fill(input logic side_d, input logic [15:0] addr);
        logic [15:0] b;
        b = addr & 16'hFFF0;
        for (int w = 0; w < 8; w++)
            sb.push_back({side_d, 3'(w), mem_word(b + 16'(2 * w))});
    endtask

    task automatic test_reset();
        rst = 1'b1; i_miss = 0; i_addr = 0; d_miss = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
        inject = 1'b1;
        @(negedge clk);
        vectors++;
        if ({mem_enable, mem_wr, fill_we_i, fill_we_d, fill_done_i, fill_done_d, fill_word, fill_data} !== 25'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: en=%b wr=%b we=%b%b done=%b%b word=%0d data=%h, required all 0", mem_enable, mem_wr, fill_we_i, fill_we_d, fill_done_i, fill_done_d, fill_word, fill_data);
        end
        vectors++;
        if ({IF_stall, MEM_stall} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_stalls: IF=%b MEM=%b, required 00", IF_stall, MEM_stall);
        end
        tick();
        rst = 1'b0;
        inject = 1'b0;
        tick();
    endtask

    task automatic test_i_fill();
        tick();
        i_miss = 1'b1; i_addr = 16'h0126;
        push_fill(1'b0, 16'h0126);
        @(negedge clk);
        vectors++;
        if ({IF_stall, mem_enable} !== 2'b10) begin
            miscompares++;
            $display("FAIL ifill_accept: IF_stall=%b mem_enable=%b, required 1 0", IF_stall, mem_enable);
        end
        for (int c = 0; c <= 12; c++) begin
            tick();
            if (c == 12) i_miss = 1'b0;
            @(negedge clk);
            vectors++;
            if (mem_enable !== (c < 8) || mem_wr !== 1'b0 || (c < 8 && mem_addr !== 16'h0120 + 16'(2 * c))) begin
                miscompares++;
                $display("FAIL ifill_issue c%0d: en=%b wr=%b addr=%h, required en=%b wr=0 addr=%h", c, mem_enable, mem_wr, mem_addr, c < 8, 16'h0120 + 16'(2 * c));
            end
            vectors++;
            if (fill_we_i !== (c >= 4 && c <= 11) || fill_done_i !== (c == 11) || IF_stall !== (c < 11)) begin
                miscompares++;
                $display("FAIL ifill_ctrl c%0d: we_i=%b done_i=%b IF_stall=%b, required %b %b %b", c, fill_we_i, fill_done_i, IF_stall, c >= 4 && c <= 11, c == 11, c < 11);
            end
        end
    endtask

    task automatic test_write();
        tick();
        d_wr = 1'b1; d_addr = 16'h4002; d_wdata = 16'hBEEF;
        @(negedge clk);
        vectors++;
        if ({MEM_stall, mem_enable} !== 2'b10) begin
            miscompares++;
            $display("FAIL write_accept: MEM_stall=%b mem_enable=%b, required 1 0", MEM_stall, mem_enable);
        end
        tick();
        @(negedge clk);
        vectors++;
        if ({mem_enable, mem_wr, mem_addr, mem_wdata, MEM_stall} !== {1'b1, 1'b1, 16'h4002, 16'hBEEF, 1'b0}) begin
            miscompares++;
            $display("FAIL write_cycle: en=%b wr=%b addr=%h wdata=%h MEM_stall=%b, required 1 1 4002 beef 0", mem_enable, mem_wr, mem_addr, mem_wdata, MEM_stall);
        end
        tick();
        d_wr = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mem_enable, MEM_stall} !== 2'b00) begin
            miscompares++;
            $display("FAIL write_end: en=%b MEM_stall=%b, required 0 0", mem_enable, MEM_stall);
        end
    endtask

    task automatic test_priority();
        tick();
        i_miss = 1'b1; i_addr = 16'h0210; d_miss = 1'b1; d_addr = 16'h3458;
        push_fill(1'b1, 16'h3458);
        push_fill(1'b0, 16'h0210);
        @(negedge clk);
        vectors++;
        if ({IF_stall, MEM_stall, mem_enable} !== 3'b110) begin
            miscompares++;
            $display("FAIL prio_accept: IF=%b MEM=%b en=%b, required 1 1 0", IF_stall, MEM_stall, mem_enable);
        end
        for (int c = 0; c <= 24; c++) begin
            logic        exp_en;
            logic [15:0] exp_addr;
            tick();
            if (c == 12) d_miss = 1'b0;
            if (c == 24) i_miss = 1'b0;
            @(negedge clk);
            exp_en   = (c < 8) || (c >= 12 && c < 20);
            exp_addr = (c < 8) ? 16'h3450 + 16'(2 * c) : 16'h0210 + 16'(2 * (c - 12));
            vectors++;
            if (mem_enable !== exp_en || (exp_en && mem_addr !== exp_addr)) begin
                miscompares++;
                $display("FAIL prio_issue c%0d: en=%b addr=%h, required en=%b addr=%h", c, mem_enable, mem_addr, exp_en, exp_addr);
            end
            vectors++;
            if (IF_stall !== (c < 23) || MEM_stall !== (c < 11) || fill_done_d !== (c == 11) || fill_done_i !== (c == 23)) begin
                miscompares++;
                $display("FAIL prio_ctrl c%0d: IF=%b MEM=%b done_d=%b done_i=%b, required %b %b %b %b", c, IF_stall, MEM_stall, fill_done_d, fill_done_i, c < 23, c < 11, c == 11, c == 23);
            end
        end
    endtask

    task automatic test_write_during_fill();
        tick();
        i_miss = 1'b1; i_addr = 16'h7A3C;
        push_fill(1'b0, 16'h7A3C);
        for (int c = 0; c <= 13; c++) begin
            tick();
            if (c == 3) begin d_wr = 1'b1; d_addr = 16'h5006; d_wdata = 16'h1234; end
            if (c == 12) i_miss = 1'b0;
            if (c == 13) d_wr = 1'b0;
            @(negedge clk);
            vectors++;
            if (MEM_stall !== (c >= 3 && c <= 11) || fill_done_i !== (c == 11)) begin
                miscompares++;
                $display("FAIL wdf_ctrl c%0d: MEM_stall=%b done_i=%b, required %b %b", c, MEM_stall, fill_done_i, c >= 3 && c <= 11, c == 11);
            end
            vectors++;
            if (mem_wr !== (c == 12) || mem_enable !== (c < 8 || c == 12) || (c == 12 && {mem_addr, mem_wdata} !== {16'h5006, 16'h1234})) begin
                miscompares++;
                $display("FAIL wdf_mem c%0d: en=%b wr=%b addr=%h wdata=%h, required en=%b wr=%b", c, mem_enable, mem_wr, mem_addr, mem_wdata, c < 8 || c == 12, c == 12);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        tick();
        d_miss = 1'b1; d_addr = 16'h9ABC;
        push_fill(1'b1, 16'h9ABC);
        for (int c = 0; c <= 5; c++) tick();
        rst = 1'b1;
        d_miss = 1'b0;
        sb.delete();
        #1;
        vectors++;
        if ({mem_enable, mem_wr, fill_we_i, fill_we_d, fill_done_i, fill_done_d, fill_word, fill_data, MEM_stall} !== 26'd0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: en=%b wr=%b we=%b%b done=%b%b word=%0d data=%h MEM=%b, required all 0", mem_enable, mem_wr, fill_we_i, fill_we_d, fill_done_i, fill_done_d, fill_word, fill_data, MEM_stall);
        end
        tick();
        rst = 1'b0;
        for (int c = 7; c <= 12; c++) begin
            @(negedge clk);
            vectors++;
            if ({fill_done_d, fill_we_d, mem_enable} !== 3'b000) begin
                miscompares++;
                $display("FAIL rstmid_quiet c%0d: done_d=%b we_d=%b en=%b, required 0 0 0", c, fill_done_d, fill_we_d, mem_enable);
            end
            tick();
        end
        d_miss = 1'b1; d_addr = 16'h1230;
        push_fill(1'b1, 16'h1230);
        for (int c = 0; c <= 12; c++) begin
            tick();
            if (c == 12) d_miss = 1'b0;
            @(negedge clk);
            vectors++;
            if (fill_done_d !== (c == 11) || (c == 0 && mem_addr !== 16'h1230)) begin
                miscompares++;
                $display("FAIL rstmid_refill c%0d: done_d=%b addr=%h, required done_d=%b", c, fill_done_d, mem_addr, c == 11);
            end
        end
    endtask

    task automatic test_idle_valid();
        tick();
        inject = 1'b1;
        @(negedge clk);
        vectors++;
        if ({fill_we_i, fill_we_d, fill_done_i, fill_done_d} !== 4'b0000) begin
            miscompares++;
            $display("FAIL idle_valid: we=%b%b done=%b%b, required 0000", fill_we_i, fill_we_d, fill_done_i, fill_done_d);
        end
        tick();
        inject = 1'b0;
        i_miss = 1'b1; i_addr = 16'hFFFE;
        push_fill(1'b0, 16'hFFFE);
        for (int c = 0; c <= 12; c++) begin
            tick();
            if (c == 12) i_miss = 1'b0;
            @(negedge clk);
            vectors++;
            if (fill_done_i !== (c == 11) || (c == 7 && mem_addr !== 16'hFFFE)) begin
                miscompares++;
                $display("FAIL idle_refill c%0d: done_i=%b addr=%h, required done_i=%b", c, fill_done_i, mem_addr, c == 11);
            end
        end
    endtask

    initial begin
        test_reset();
        test_i_fill();
        test_write();
        test_priority();
        test_write_during_fill();
        test_reset_mid_fill();
        test_idle_valid();
        tick();
        tick();
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL sb_drained: %0d words outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
